// File: rtl/rns_forward_converter_if.sv
// Handshake bundle for the binary-to-RNS forward converter: operand in, residue triple out.
// slave is the converter's view; master is the producer/consumer environment.
interface rns_forward_converter_if #(
  parameter int unsigned N = 3
);
  logic [3*N-1:0] bin_in;
  logic           valid_in;
  logic           ready_out;
  logic [N-1:0]   r1_out;
  logic [N-1:0]   r2_out;
  logic [N:0]     r3_out;
  logic           err_out;
  logic           valid_out;
  logic           ready_in;

  modport master (
    output bin_in,
    output valid_in,
    output ready_in,
    input  ready_out,
    input  r1_out,
    input  r2_out,
    input  r3_out,
    input  err_out,
    input  valid_out
  );

  modport slave (
    input  bin_in,
    input  valid_in,
    input  ready_in,
    output ready_out,
    output r1_out,
    output r2_out,
    output r3_out,
    output err_out,
    output valid_out
  );
endinterface

// File: rtl/rns_forward_converter.sv
// Two-stage binary -> RNS {2^N-1, 2^N, 2^N+1} converter with canonical residues.
// Define RNS_FWD_RANGE_CHECK_EN to flag operands >= 2^(3N)-2^N on err_out.
module rns_forward_converter #(
  parameter int unsigned N = 3
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  rns_forward_converter_if.slave bus
);
  localparam int unsigned W = 3 * N;
  localparam logic [N:0]   ModLo = {1'b0, {N{1'b1}}};
  localparam logic [N+1:0] ModHi = {2'b01, {(N-1){1'b0}}, 1'b1};

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic adv1, adv2, load1, load2;

  always_comb begin
    adv2  = ~s2_valid_q | bus.ready_in;
    adv1  = ~s1_valid_q | adv2;
    load1 = adv1 & bus.valid_in;
    load2 = adv2 & s1_valid_q;
  end

  assign bus.ready_out = adv1;
  assign bus.valid_out = s2_valid_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (adv1) s1_valid_q <= bus.valid_in;
      if (adv2) s2_valid_q <= s1_valid_q;
    end
  end

  // Stage 1: chunk sums
  logic [N-1:0] c0, c1, c2;
  logic [N+1:0] s7_d, s9_d;
  logic [N+1:0] s7_q, s9_q;
  logic [N-1:0] c0_q;

  always_comb begin
    c0   = bus.bin_in[N-1:0];
    c1   = bus.bin_in[2*N-1:N];
    c2   = bus.bin_in[W-1:2*N];
    s7_d = {2'b00, c0} + {2'b00, c1} + {2'b00, c2};
    // 2^N == -1 mod 2^N+1; the added modulus keeps the difference positive
    s9_d = {2'b00, c0} + {2'b00, c2} + ModHi - {2'b00, c1};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s7_q <= '0;
      s9_q <= '0;
      c0_q <= '0;
    end else if (load1) begin
      s7_q <= s7_d;
      s9_q <= s9_d;
      c0_q <= c0;
    end
  end

  // Stage 2: end-around fold and bounded modular reduction
  logic [N:0]   fold;
  logic [N+1:0] red;
  logic [N-1:0] r1_d;
  logic [N:0]   r3_d;
  logic [N-1:0] r1_q, r2_q;
  logic [N:0]   r3_q;

  always_comb begin
    fold = {1'b0, s7_q[N-1:0]} + {{(N-1){1'b0}}, s7_q[N+1:N]};
    // Folding to exactly 2^N-1 is the alias of zero
    r1_d = (fold >= ModLo) ? N'(fold - ModLo) : N'(fold);
    red  = s9_q;
    if (red >= ModHi) red = red - ModHi;
    if (red >= ModHi) red = red - ModHi;
    r3_d = (N+1)'(red);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else if (load2) begin
      r1_q <= r1_d;
      r2_q <= c0_q;
      r3_q <= r3_d;
    end
  end

  assign bus.r1_out = r1_q;
  assign bus.r2_out = r2_q;
  assign bus.r3_out = r3_q;

`ifdef RNS_FWD_RANGE_CHECK_EN
  // Operand >= 2^(3N)-2^N exactly when every bit above the low chunk is set
  logic s1_err_q, s2_err_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_err_q <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      if (load1) s1_err_q <= &bus.bin_in[W-1:N];
      if (load2) s2_err_q <= s1_err_q;
    end
  end

  assign bus.err_out = s2_err_q;
`else
  assign bus.err_out = 1'b0;
`endif
endmodule

// File: tb/tb_rns_forward_converter.sv
// Scoreboard bench for rns_forward_converter (N=3): directed vectors, stream, stalls, reset.
module tb_rns_forward_converter;
  localparam int unsigned N = 3;

  typedef struct packed {
    logic [2:0] r1;
    logic [2:0] r2;
    logic [3:0] r3;
    logic       err;
  } exp_t;

`ifdef RNS_FWD_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   n_sent = 0;
  int   gap_cnt = 0;
  bit   stream_chk = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  rns_forward_converter_if #(.N(N)) bus ();

  rns_forward_converter #(.N(N)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid_out & ready_in
  always @(negedge clk) begin
    if (rst_n && bus.valid_out && bus.ready_in) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("r1", int'(bus.r1_out), int'(mon_e.r1));
        chk("r2", int'(bus.r2_out), int'(mon_e.r2));
        chk("r3", int'(bus.r3_out), int'(mon_e.r3));
        chk("err", int'(bus.err_out), int'(mon_e.err));
        n_out++;
      end
    end
    if (stream_chk && !bus.valid_out) gap_cnt++;
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input int x, input int e1, input int e2, input int e3, input int ee);
    int guard = 0;
    bus.bin_in   = 9'(x);
    bus.valid_in = 1'b1;
    while (!bus.ready_out) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        $display("FAIL send_timeout: got ready_out=0 for 100 cycles, required 1");
        $fatal(1);
      end
    end
    sb.push_back(exp_t'{r1: 3'(e1), r2: 3'(e2), r3: 4'(e3), err: 1'(ee)});
    n_sent++;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk);
    #1 bus.ready_in = v;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    chk("out_count", n_out, n_sent);
  endtask

  initial begin
    bus.bin_in   = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    #1;
    chk("rst_valid_out", int'(bus.valid_out), 0);
    chk("rst_r1", int'(bus.r1_out), 0);
    chk("rst_r2", int'(bus.r2_out), 0);
    chk("rst_r3", int'(bus.r3_out), 0);
    chk("rst_err", int'(bus.err_out), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_out", int'(bus.ready_out), 1);
    chk("post_rst_valid_out", int'(bus.valid_out), 0);

    // Single transfers and latency
    set_ready(1'b1);
    send(100, 2, 4, 1, 0);
    chk("latency_cycle1_valid", int'(bus.valid_out), 0);
    @(negedge clk);
    chk("latency_cycle2_valid", int'(bus.valid_out), 1);
    send(0, 0, 0, 0, 0);
    send(503, 6, 7, 8, 0);
    send(63, 0, 7, 0, 0);
    send(504, 0, 0, 0, int'(RangeEn));
    wait_drain();

    // Back-to-back stream
    for (int x = 0; x < 504; x++) begin
      send(x, x % 7, x % 8, x % 9, 0);
      if (x == 1) stream_chk = 1'b1;
    end
    stream_chk = 1'b0;
    chk("stream_gap", gap_cnt, 0);
    wait_drain();

    // Backpressure: two values fill the pipe, third waits
    set_ready(1'b0);
    send(10, 3, 2, 1, 0);
    send(20, 6, 4, 2, 0);
    chk("bp_ready_out", int'(bus.ready_out), 0);
    fork
      send(30, 2, 6, 3, 0);
      begin
        for (int i = 0; i < 4; i++) begin
          chk("bp_hold_valid", int'(bus.valid_out), 1);
          chk("bp_hold_r1", int'(bus.r1_out), 3);
          chk("bp_hold_r2", int'(bus.r2_out), 2);
          chk("bp_hold_r3", int'(bus.r3_out), 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1 bus.ready_in = 1'b1;
      end
    join
    wait_drain();

    // Reset with both stages full
    set_ready(1'b0);
    send(10, 3, 2, 1, 0);
    send(20, 6, 4, 2, 0);
    chk("full_before_rst", int'(bus.valid_out), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_out", int'(bus.valid_out), 0);
    chk("async_rst_r1", int'(bus.r1_out), 0);
    chk("async_rst_r2", int'(bus.r2_out), 0);
    chk("async_rst_r3", int'(bus.r3_out), 0);
    chk("async_rst_err", int'(bus.err_out), 0);
    n_sent -= sb.size();
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_ready(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("no_stale_valid", int'(bus.valid_out), 0);
      @(negedge clk);
    end
    send(63, 0, 7, 0, 0);
    send(100, 2, 4, 1, 0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rns_forward_converter.md
Name: rns_forward_converter

Overview:
- Binary-to-RNS forward converter for the moduli set {2^N-1, 2^N, 2^N+1}. With N=3 this is {7, 8, 9}.
- Produces the residue triples consumed by the RNS comparator and arithmetic blocks.
- Two-stage pipeline with a valid/ready handshake on both sides.
- Output residues are always canonical, so downstream blocks never see the all-ones alias of zero for modulus 2^N-1.

Parameters:
- N, 3, moduli base; supported range 3..8.
- Derived: input width W = 3N; dynamic range M = 2^(3N) - 2^N, which is 504 for N=3.

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  asynchronous reset, active low
- bin_in  input  3N  unsigned binary operand
- valid_in  input  1  bin_in is valid
- ready_out  output  1  converter accepts bin_in this cycle
- r1_out  output  N  residue mod 2^N-1, canonical range 0..2^N-2
- r2_out  output  N  residue mod 2^N
- r3_out  output  N+1  residue mod 2^N+1, range 0..2^N
- err_out  output  1  input was out of range (see Optional Feature)
- valid_out  output  1  residue triple is valid
- ready_in  input  1  downstream accepts the triple

Behaviour:
- Reset: asynchronous and active-low. While rst_n_in=0, all pipeline registers clear immediately: valid_out=0, r1_out=r2_out=r3_out=0, err_out=0. ready_out=1 from the first cycle after release.
- Chunking: split bin_in into c0=bin_in[N-1:0], c1=bin_in[2N-1:N], c2=bin_in[3N-1:2N].
- Stage 1 registers:
  - s7 = c0+c1+c2, width N+2.
  - s9 = c0 + c2 + (2^N+1) - c1, width N+2, range 2..3*2^N-1.
  - c0 as-is.
  - s1_err.
- Stage 2 registers:
  - r1: f = s7[N-1:0] + s7[N+1:N]. If f >= 2^N-1, subtract 2^N-1. Result is never 2^N-1.
  - r2 = c0 (the stage-1 copy).
  - r3: subtract 2^N+1 from s9 while s9 >= 2^N+1, at most twice.
  - err_out = s1_err.
- Latency: exactly 2 cycles from an accepted input (valid_in & ready_out) to valid_out, when no stall occurs. Throughput is 1 per cycle.
- Handshake and stalls:
  - Output advance: adv2 = ~s2_valid | ready_in. Stage-1 advance: adv1 = ~s1_valid | adv2.
  - ready_out = adv1. This is combinational from ready_in; no combinational path from valid_in to ready_out.
  - A stage loads only when it advances. Its valid clears when it advances with no incoming data.
  - While valid_out=1 and ready_in=0, all outputs hold stable.
  - No transfer is ever duplicated or dropped.
- Simultaneous events: when an output is accepted and a new input is accepted in the same cycle, both transfers complete; the pipeline stays full.
- Reset mid-operation discards all in-flight data. No partial output appears after reset release.
- Boundary values:
  - bin_in = 0 gives (0,0,0).
  - Any c-chunk combination whose r1 sum folds to exactly 2^N-1 gives r1 = 0.

Optional Feature:
- Macro: RNS_FWD_RANGE_CHECK_EN.
- Defined:
  - s1_err = 1 when bin_in >= M, i.e. bin_in[3N-1:N] is all ones.
  - err_out travels with its data.
  - Residues are still computed from bin_in (value aliased mod M).
- Undefined: err_out is tied to 0 and no comparison logic is built. All other behaviour is identical.

Test Plan:
- Single transfers with N=3, ready_in=1. Each output appears 2 cycles after acceptance, err_out=0:
  - bin_in=100 -> (r1,r2,r3)=(2,4,1)
  - bin_in=0 -> (0,0,0)
  - bin_in=503 -> (6,7,8)
- Canonical fold: bin_in=63 (chunks 7,7,0) -> r1=0, not 7; r2=7, r3=0.
- Back-to-back stream: bin_in=0..503 on consecutive cycles with ready_in=1 -> 504 outputs in order, matching x mod 7/8/9. valid_out continuously high after 2 cycles.
- Backpressure: send 3 values (10, 20, 30) while ready_in=0 for 5 cycles.
  - Required: ready_out drops after 2 are buffered.
  - Outputs hold at (3,2,1) for 10.
  - After ready_in=1: (3,2,1), (6,4,2), (2,6,3) in order, none lost or repeated.
- Range check: bin_in=504 with RNS_FWD_RANGE_CHECK_EN -> err_out=1, residues (0,0,0). Without the macro -> err_out=0.
- Reset mid-stream: assert rst_n_in for 1 cycle with both stages full.
  - Required: valid_out=0 and outputs 0 immediately, asynchronously.
  - No stale output after release. The next input converts correctly.
